status_flag_unit: RTL and testbench

STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

---
 rtl/arm_defs_pkg.sv | 60 ++++++
 rtl/status_flag_unit_if.sv | 28 ++
 rtl/status_flag_unit_cond_check.sv | 35 +++
 rtl/status_flag_unit.sv | 52 +++++
 tb/tb_status_flag_unit.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/arm_defs_pkg.sv
// Shared ARM-style ALU command encodings, condition codes and flag layout.
// Imported by the ALU and by the status flag unit.
package arm_defs_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000
  } alu_cmd_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_LOGIC = 2'd1,
    CLS_ARITH = 2'd2
  } cmd_class_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Arithmetic ops own C/V; logical/move ops only touch N/Z; anything else is not a flag writer.
  function automatic cmd_class_e cmd_class(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC:          return CLS_ARITH;
      CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR: return CLS_LOGIC;
      default:                                     return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/status_flag_unit_if.sv
// EXE-stage flag bus: ALU result/command in, registered flags and condition verdict out.
interface status_flag_unit_if;

  logic [arm_defs_pkg::DATA_W-1:0] alu_out;
  logic                            alu_c;
  logic                            alu_v;
  logic [3:0]                      exe_cmd;
  logic                            s_bit;
  logic                            exe_valid;
  logic                            stall;
  logic                            flush;
  logic [3:0]                      cond;
  logic [3:0]                      nzcv;
  logic                            carry_in;
  logic                            cond_pass;
  logic                            flag_busy;

  modport master (
    output alu_out, alu_c, alu_v, exe_cmd, s_bit, exe_valid, stall, flush, cond,
    input  nzcv, carry_in, cond_pass, flag_busy
  );

  modport slave (
    input  alu_out, alu_c, alu_v, exe_cmd, s_bit, exe_valid, stall, flush, cond,
    output nzcv, carry_in, cond_pass, flag_busy
  );

endinterface

// File: rtl/status_flag_unit_cond_check.sv
// Purely combinational ARM condition-code evaluator over a {N,Z,C,V} flag word.
module cond_check
  import arm_defs_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  flags_t f;

  always_comb begin
    f    = flags_t'(nzcv);
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = f.z;
      COND_NE: pass = ~f.z;
      COND_CS: pass = f.c;
      COND_CC: pass = ~f.c;
      COND_MI: pass = f.n;
      COND_PL: pass = ~f.n;
      COND_VS: pass = f.v;
      COND_VC: pass = ~f.v;
      COND_HI: pass = f.c & ~f.z;
      COND_LS: pass = ~f.c | f.z;
      COND_GE: pass = (f.n == f.v);
      COND_LT: pass = (f.n != f.v);
      COND_GT: pass = ~f.z & (f.n == f.v);
      COND_LE: pass = f.z | (f.n != f.v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_flag_unit.sv
// NZCV status register with same-cycle bypass into condition evaluation for the ID stage.
module status_flag_unit
  import arm_defs_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  status_flag_unit_if.slave  bus
);

  flags_t     nzcv_p1;
  flags_t     nzcv_nxt_p0;
  cmd_class_e cls_p0;
  logic       upd_p0;

  // p0: decide whether EXE commits flags this cycle and form the next flag word.
  // Gating with rst keeps busy low and the bypass path at 0000 while reset is held.
  always_comb begin
    cls_p0      = cmd_class(bus.exe_cmd);
    upd_p0      = rst & bus.exe_valid & bus.s_bit & ~bus.stall & ~bus.flush &
                  (cls_p0 != CLS_NONE);
    nzcv_nxt_p0 = nzcv_p1;
    if (upd_p0) begin
      nzcv_nxt_p0.n = bus.alu_out[DATA_W-1];
      nzcv_nxt_p0.z = (bus.alu_out == '0);
      if (cls_p0 == CLS_ARITH) begin
        nzcv_nxt_p0.c = bus.alu_c;
        nzcv_nxt_p0.v = bus.alu_v;
      end
    end
  end

  // p1: the architectural flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nzcv_p1 <= '0;
    end else if (upd_p0) begin
      nzcv_p1 <= nzcv_nxt_p0;
    end
  end

  // nzcv_nxt_p0 equals nzcv_p1 whenever no update is committing, so it is the effective flag word.
  cond_check u_cond_check (
    .cond (bus.cond),
    .nzcv (nzcv_nxt_p0),
    .pass (bus.cond_pass)
  );

  assign bus.nzcv      = nzcv_p1;
  assign bus.carry_in  = nzcv_p1.c;
  assign bus.flag_busy = upd_p0;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed-vector bench for status_flag_unit with a queue-based scoreboard and negedge monitor.
module tb_status_flag_unit;

  logic clk;
  logic rst;

  status_flag_unit_if bus ();

  status_flag_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] nzcv;
    logic       cin;
    logic       pass;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %b expected %b", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, half a cycle after stimulus settles.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.name, "nzcv",      bus.nzcv,              e.nzcv);
      check(e.name, "carry_in",  {3'b0, bus.carry_in},  {3'b0, e.cin});
      check(e.name, "cond_pass", {3'b0, bus.cond_pass}, {3'b0, e.pass});
      check(e.name, "flag_busy", {3'b0, bus.flag_busy}, {3'b0, e.busy});
    end
  end

  // One cycle of stimulus: drive 1 time unit after the rising edge, optionally pull reset mid-cycle.
  task automatic step(input string nm, input logic r, input logic mid_r,
                      input logic [3:0] cmd, input logic [31:0] out,
                      input logic c, input logic v, input logic s, input logic vld,
                      input logic stl, input logic fls, input logic [3:0] cnd,
                      input logic [3:0] e_nzcv, input logic e_cin, input logic e_pass,
                      input logic e_busy);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.exe_cmd   = cmd;
    bus.alu_out   = out;
    bus.alu_c     = c;
    bus.alu_v     = v;
    bus.s_bit     = s;
    bus.exe_valid = vld;
    bus.stall     = stl;
    bus.flush     = fls;
    bus.cond      = cnd;
    e.name = nm; e.nzcv = e_nzcv; e.cin = e_cin; e.pass = e_pass; e.busy = e_busy;
    sb_q.push_back(e);
    if (mid_r) begin
      #2;
      rst = 1'b0;
    end
  endtask

  logic [15:0] sweep_exp;

  initial begin
    rst           = 1'b0;
    bus.exe_cmd   = 4'b0000;
    bus.alu_out   = 32'h0;
    bus.alu_c     = 1'b0;
    bus.alu_v     = 1'b0;
    bus.s_bit     = 1'b0;
    bus.exe_valid = 1'b0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.cond      = 4'b0000;

    //    name          rst mid cmd      alu_out       c  v  s  vld stl fls cond     nzcv     cin pass busy
    step("rst_ne",      0,  0,  4'b0000, 32'h0,        0, 0, 0, 0,  0,  0,  4'b0001, 4'b0000, 0,  1,   0);
    step("rst_eq_upd",  0,  0,  4'b0010, 32'h0,        1, 0, 1, 1,  0,  0,  4'b0000, 4'b0000, 0,  0,   0);
    step("rst_rel_al",  1,  0,  4'b0000, 32'h0,        0, 0, 0, 0,  0,  0,  4'b1110, 4'b0000, 0,  1,   0);
    step("sub_zero",    1,  0,  4'b0100, 32'h0,        1, 0, 1, 1,  0,  0,  4'b0000, 4'b0000, 0,  1,   1);
    step("sub_after",   1,  0,  4'b0000, 32'h0,        0, 0, 0, 0,  0,  0,  4'b0000, 4'b0110, 1,  1,   0);
    step("adc_vs",      1,  0,  4'b0011, 32'h1,        1, 1, 1, 1,  0,  0,  4'b0110, 4'b0110, 1,  1,   1);
    step("eor_mi",      1,  0,  4'b1000, 32'h8000_0000,0, 0, 1, 1,  0,  0,  4'b0100, 4'b0011, 1,  1,   1);
    step("eor_after",   1,  0,  4'b0000, 32'h0,        0, 0, 0, 0,  0,  0,  4'b0010, 4'b1011, 1,  1,   0);
    step("add_stall",   1,  0,  4'b0010, 32'h0,        0, 0, 1, 1,  1,  0,  4'b0000, 4'b1011, 1,  0,   0);
    step("add_flush",   1,  0,  4'b0010, 32'h0,        0, 0, 1, 1,  0,  1,  4'b0000, 4'b1011, 1,  0,   0);
    step("add_both",    1,  0,  4'b0010, 32'h0,        0, 0, 1, 1,  1,  1,  4'b0000, 4'b1011, 1,  0,   0);
    step("add_no_s",    1,  0,  4'b0010, 32'h0,        0, 0, 0, 1,  0,  0,  4'b0000, 4'b1011, 1,  0,   0);
    step("add_no_vld",  1,  0,  4'b0010, 32'h0,        0, 0, 1, 0,  0,  0,  4'b0000, 4'b1011, 1,  0,   0);
    step("bad_cmd0",    1,  0,  4'b0000, 32'h0,        0, 0, 1, 1,  0,  0,  4'b0000, 4'b1011, 1,  0,   0);
    step("bad_cmda",    1,  0,  4'b1010, 32'h0,        0, 1, 1, 1,  0,  0,  4'b0110, 4'b1011, 1,  1,   0);
    step("add_ge",      1,  0,  4'b0010, 32'h8000_0001,0, 1, 1, 1,  0,  0,  4'b1010, 4'b1011, 1,  1,   1);

    sweep_exp = 16'h565A;
    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep_c%0d", i), 1, 0, 4'b0000, 32'h0, 0, 0, 0, 0, 0, 0,
           4'(i), 4'b1001, 0, sweep_exp[i], 0);
    end

    //    name          rst mid cmd      alu_out       c  v  s  vld stl fls cond     nzcv     cin pass busy
    step("b2b_mov",     1,  0,  4'b0001, 32'h0,        1, 0, 1, 1,  0,  0,  4'b0000, 4'b1001, 0,  1,   1);
    step("b2b_sbc",     1,  0,  4'b0101, 32'h7fff_ffff,1, 0, 1, 1,  0,  0,  4'b1100, 4'b0101, 0,  1,   1);
    step("b2b_mvn",     1,  0,  4'b1001, 32'hffff_ffff,0, 1, 1, 1,  0,  0,  4'b1011, 4'b0010, 1,  1,   1);
    step("b2b_orr",     1,  0,  4'b0111, 32'h0,        0, 0, 1, 1,  0,  0,  4'b1000, 4'b1010, 1,  0,   1);
    step("b2b_and",     1,  0,  4'b0110, 32'h5,        0, 0, 1, 1,  0,  0,  4'b1001, 4'b0110, 1,  0,   1);
    step("b2b_after",   1,  0,  4'b0000, 32'h0,        0, 0, 0, 0,  0,  0,  4'b1000, 4'b0010, 1,  1,   0);
    step("arst_mid",    1,  1,  4'b0010, 32'h8000_0000,1, 1, 1, 1,  0,  0,  4'b0100, 4'b0000, 0,  0,   0);
    step("arst_hold",   0,  0,  4'b0010, 32'h8000_0000,1, 1, 1, 1,  0,  0,  4'b1110, 4'b0000, 0,  1,   0);
    step("arst_rel",    1,  0,  4'b0010, 32'h8000_0000,1, 1, 1, 1,  0,  0,  4'b0001, 4'b0000, 0,  1,   1);
    step("arst_commit", 1,  0,  4'b0000, 32'h0,        0, 0, 0, 0,  0,  0,  4'b0110, 4'b1011, 1,  1,   0);

    for (int k = 0; k < 8 && sb_q.size() != 0; k++) @(negedge clk);
    #1;
    check("drain", "queue_left", 4'(sb_q.size()), 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "simulation timeout");
  end

endmodule
